// File: rtl/store_buffer.sv
// store_buffer: write buffer between the MEM-stage pipeline and data memory.
// Stores are queued in a circular FIFO of {word_addr, data}. The FIFO drains
// into the memory write port whenever the pipeline does not claim it.
// Younger loads to a buffered word get the youngest buffered data forwarded.
//
// Optional build macro: STORE_COALESCE_EN. When it is defined, a store to the
// same word as the youngest held entry overwrites that entry in place.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   st_valid/st_addr/st_data   store from pipeline; st_ready = accepted
//   ld_valid/ld_addr           load lookup; ld_hit/ld_data = forwarded word
//   mem_busy                   memory port claimed by a load this cycle
//   mem_WriteEn/addr/data      write port to data memory (head entry)
//   empty, count               occupancy
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_data,
    input  logic                     mem_busy,
    output logic                     mem_WriteEn,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WA = ADDR_W - 2;

    logic [WA-1:0]     addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head, tail, last_idx;
    logic [CW-1:0]     count_q;
    logic              full, pop, push, coal;
    logic [WA-1:0]     st_wa, ld_wa;

    assign st_wa    = st_addr[ADDR_W-1:2];
    assign ld_wa    = ld_addr[ADDR_W-1:2];
    assign last_idx = tail - PW'(1);
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop      = !empty && !mem_busy;

`ifdef STORE_COALESCE_EN
    // The youngest entry is the head only when count==1; if that head is
    // leaving this cycle the store must take a fresh slot instead.
    assign coal     = st_valid && !empty && (addr_q[last_idx] == st_wa) &&
                      !(pop && count_q == CW'(1));
    assign st_ready = !full || coal;
`else
    assign coal     = 1'b0;
    assign st_ready = !full;
`endif

    assign push = st_valid && st_ready && !coal;

    assign mem_WriteEn = pop;
    assign mem_addr    = empty ? '0 : {addr_q[head], 2'b00};
    assign mem_data    = empty ? '0 : data_q[head];

    // Walk oldest to youngest so the last match wins.
    logic              hit_any;
    logic [DATA_W-1:0] hit_data;
    logic [PW-1:0]     idx;
    always_comb begin
        hit_any  = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count_q && addr_q[idx] == ld_wa) begin
                hit_any  = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign ld_hit  = ld_valid && hit_any;
    assign ld_data = ld_hit ? hit_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_q[tail] <= st_wa;
                data_q[tail] <= st_data;
                tail         <= tail + PW'(1);
            end
            if (coal)
                data_q[last_idx] <= st_data;
            if (pop)
                head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed-vector bench for store_buffer with hand-computed expectations.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid, st_ready, ld_valid, ld_hit, mem_busy, mem_WriteEn, empty;
    logic [31:0] st_addr, st_data, ld_addr, ld_data, mem_addr, mem_data;
    logic [2:0]  count;

    int nvec = 0;
    int nerr = 0;

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .mem_busy(mem_busy), .mem_WriteEn(mem_WriteEn), .mem_addr(mem_addr),
        .mem_data(mem_data), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1; st_addr = a; st_data = d;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic drain_all();
        int n;
        mem_busy = 1'b0;
        st_valid = 1'b0;
        n = 0;
        #1;
        while (!empty && n < 20) begin
            tick();
            n++;
        end
        chk("drain_done", {31'd0, empty}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; st_valid = 0; st_addr = 0; st_data = 0;
        ld_valid = 0; ld_addr = 0; mem_busy = 0;
        #12;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_ready", {31'd0, st_ready}, 32'd1);
        chk("rst_wen",   {31'd0, mem_WriteEn}, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mdata", mem_data, 32'd0);
        ld_valid = 1; #1;
        chk("rst_ldhit", {31'd0, ld_hit}, 32'd0);
        chk("rst_lddata", ld_data, 32'd0);
        ld_valid = 0;
        reset = 1'b0;
        tick();

        // single store, 1-cycle latency to memory
        st_valid = 1; st_addr = 32'h10; st_data = 32'hAABBCCDD; #1;
        chk("t1_no_bypass", {31'd0, mem_WriteEn}, 32'd0);
        tick();
        st_valid = 0; #1;
        chk("t1_wen",   {31'd0, mem_WriteEn}, 32'd1);
        chk("t1_maddr", mem_addr, 32'h10);
        chk("t1_mdata", mem_data, 32'hAABBCCDD);
        chk("t1_cnt1",  {29'd0, count}, 32'd1);
        tick();
        chk("t1_empty", {31'd0, empty}, 32'd1);
        chk("t1_cnt0",  {29'd0, count}, 32'd0);
        chk("t1_wen0",  {31'd0, mem_WriteEn}, 32'd0);

        // fill while busy; low address bits ignored
        mem_busy = 1;
        store(32'h1, 32'hA0);
        store(32'h4, 32'hA1);
        store(32'h8, 32'hA2);
        store(32'hC, 32'hA3);
        chk("t2_cnt4",  {29'd0, count}, 32'd4);
        chk("t2_nrdy",  {31'd0, st_ready}, 32'd0);
        chk("t2_busy_wen", {31'd0, mem_WriteEn}, 32'd0);
        st_valid = 1; st_addr = 32'h100; st_data = 32'h5;
        tick();
        chk("t2_held",  {29'd0, count}, 32'd4);
        mem_busy = 0; #1;
        chk("t2_nrdy_pop", {31'd0, st_ready}, 32'd0);
        chk("t2_w0", mem_addr, 32'h0);
        chk("t2_d0", mem_data, 32'hA0);
        tick();
        chk("t2_cnt3", {29'd0, count}, 32'd3);
        chk("t2_rdy",  {31'd0, st_ready}, 32'd1);
        chk("t2_w1",   mem_addr, 32'h4);
        tick();
        st_valid = 0; #1;
        chk("t2_cnt3b", {29'd0, count}, 32'd3);
        chk("t2_w2",   mem_addr, 32'h8);
        tick();
        chk("t2_w3",   mem_addr, 32'hC);
        tick();
        chk("t2_w4",   mem_addr, 32'h100);
        chk("t2_d4",   mem_data, 32'h5);
        tick();
        chk("t2_empty", {31'd0, empty}, 32'd1);

        // forwarding, youngest wins
        mem_busy = 1;
        store(32'h20, 32'h1);
        store(32'h20, 32'h2);
`ifdef STORE_COALESCE_EN
        chk("t3_cnt", {29'd0, count}, 32'd1);
`else
        chk("t3_cnt", {29'd0, count}, 32'd2);
`endif
        ld_valid = 1; ld_addr = 32'h22; #1;
        chk("t3_hit",   {31'd0, ld_hit}, 32'd1);
        chk("t3_data",  ld_data, 32'h2);
        ld_addr = 32'h24; #1;
        chk("t3_miss",  {31'd0, ld_hit}, 32'd0);
        chk("t3_mdata", ld_data, 32'h0);
        ld_valid = 0; ld_addr = 32'h20; #1;
        chk("t3_novld", {31'd0, ld_hit}, 32'd0);
        // not-yet-accepted store is not forwarded
        ld_valid = 1; ld_addr = 32'h28; st_valid = 1; st_addr = 32'h28; st_data = 32'h9; #1;
        chk("t3_nofwd_new", {31'd0, ld_hit}, 32'd0);
        st_valid = 0; ld_valid = 0;
        drain_all();

        // simultaneous push/pop at count=2, pointers wrap
        mem_busy = 1;
        store(32'h30, 32'h30);
        store(32'h34, 32'h34);
        mem_busy = 0;
        for (int i = 0; i < 6; i++) begin
            st_valid = 1; st_addr = 32'h200 + 32'(4 * i); st_data = 32'h200 + 32'(i);
            #1;
            chk("t4_cnt", {29'd0, count}, 32'd2);
            chk("t4_head", mem_addr, (i < 2) ? 32'h30 + 32'(4 * i) : 32'h200 + 32'(4 * (i - 2)));
            tick();
        end
        st_valid = 0; #1;
        chk("t4_head_end", mem_addr, 32'h210);
        chk("t4_data_end", mem_data, 32'h204);
        drain_all();

        // async reset mid-drain discards pending stores
        mem_busy = 1;
        store(32'h50, 32'h1);
        store(32'h54, 32'h2);
        store(32'h58, 32'h3);
        chk("t5_cnt3", {29'd0, count}, 32'd3);
        mem_busy = 0; #2;
        reset = 1; #1;
        chk("t5_wen",   {31'd0, mem_WriteEn}, 32'd0);
        chk("t5_cnt",   {29'd0, count}, 32'd0);
        chk("t5_maddr", mem_addr, 32'd0);
        chk("t5_mdata", mem_data, 32'd0);
        tick();
        reset = 0;
        ld_valid = 1; ld_addr = 32'h50;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_nowrite", {31'd0, mem_WriteEn}, 32'd0);
            chk("t5_noldhit", {31'd0, ld_hit}, 32'd0);
        end
        ld_valid = 0;

        // full buffer, store to youngest word
        mem_busy = 1;
        store(32'h60, 32'h60);
        store(32'h64, 32'h64);
        store(32'h68, 32'h68);
        store(32'h40, 32'h40);
        chk("t6_full", {29'd0, count}, 32'd4);
        st_valid = 1; st_addr = 32'h40; st_data = 32'h55; #1;
`ifdef STORE_COALESCE_EN
        chk("t6_rdy_coal", {31'd0, st_ready}, 32'd1);
        tick();
        st_valid = 0;
        ld_valid = 1; ld_addr = 32'h40; #1;
        chk("t6_cnt", {29'd0, count}, 32'd4);
        chk("t6_fwd", ld_data, 32'h55);
        st_valid = 1; st_addr = 32'h44; st_data = 32'h66; #1;
        chk("t6_stall", {31'd0, st_ready}, 32'd0);
`else
        chk("t6_rdy_full", {31'd0, st_ready}, 32'd0);
        tick();
        ld_valid = 1; ld_addr = 32'h40; #1;
        chk("t6_cnt", {29'd0, count}, 32'd4);
        chk("t6_fwd", ld_data, 32'h40);
`endif
        st_valid = 0; ld_valid = 0;
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
